wordle_scorer: RTL and testbench
================================

Name: wordle_scorer

Overview:
- Scores a committed 5-letter guess against the target word and returns per-position Wordle feedback: green, yellow or gray.
- Sits on the response side of the guess path. The game state machine hands over a full guess plus target with a start pulse; this block returns a registered result and a one-cycle done pulse.
- Handles duplicate letters with standard Wordle rules: greens consume target letters first, then yellows are assigned left to right.

Parameters:
- N_LETTERS, 5, letters per word; the design and the tests are fixed at 5, and the parameter exists for readability only.
- CHAR_W, 8, bits per letter (ASCII byte).

Ports:
- Clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only while ready=1.
- guess  in  40  guess word; first letter is in [39:32], fifth letter in [7:0].
- target  in  40  target word, same byte order as guess.
- ready  out  1  high in IDLE; start is accepted only when ready=1.
- done  out  1  one-cycle pulse; result and win are valid from this cycle on.
- result  out  10  2 bits per position; [9:8] is the first letter. Encoding: 00 gray, 01 yellow, 10 green, 11 never produced.
- win  out  1  high when all five positions are green.

Behaviour:
- Reset (synchronous, any state): state goes to IDLE; ready=1, done=0, result=0, win=0; internal latches and consumed flags are cleared. Reset mid-scoring abandons the job and produces no done pulse.
- Accept: on an edge with state=IDLE and start=1, guess and target are latched into internal registers, consumed[4:0] is cleared, the working result is cleared, and state goes to GREEN. Later changes on the guess and target inputs have no effect on the job.
- While busy, start is ignored. It is not queued.
- GREEN (1 cycle): compare all positions in parallel. Where the guess byte equals the target byte, mark green and set consumed[i].
- YELLOW (5 cycles, idx = 0..4, one guess position per cycle):
  - If position idx is already green, skip it.
  - Otherwise, find the lowest target index j with consumed[j]=0 and target[j]=guess[idx]. If found, mark idx yellow and set consumed[j]. If not, idx stays gray.
  - consumed updates take effect before the next idx is evaluated.
- DONE (1 cycle): done=1, and result and win are updated. Then state returns to IDLE.
- Latency: the accept edge is edge 0 and done is high in the cycle after edge 6. A new start is accepted no earlier than the edge that ends the DONE cycle + 1, i.e. while in IDLE.
- After done, result and win hold their values until the next accept edge, which clears them to 0.
- Bytes are compared raw. No case folding and no letter-validity check.
- A byte equal to 0 is scored like any other value; callers must not submit partial words.
- win = (result == 10'b10_10_10_10_10), registered with result.

Decomposition:
- wordle_pkg holds: the color codes (GRAY=2'b00, YELLOW=2'b01, GREEN=2'b10), the state encodings, and the constants N_LETTERS and CHAR_W. The game state machine and the display driver share these.
- One combinational sub-module, wordle_letter_find. Inputs: one letter, the 40-bit target and the consumed mask. Outputs: found and a one-hot index of the lowest matching unconsumed position. It is instantiated once and used in the YELLOW state.

Test Plan:
- Exact match: target "ROBOT", guess "ROBOT", start pulse. Expect done exactly 7 cycles after the start cycle, result=10'b1010101010, win=1, ready=0 during scoring.
- Anagram, all yellow except one green: target "LAPSE", guess "PALES". Expect result=01_10_01_01_01, win=0.
- Excess duplicates: target "CACAO", guess "AAAAA". Expect 00_10_00_10_00; no extra yellows for the remaining A's.
- Duplicate yellow consumption: target "ABBOT", guess "BOBBY". Expect 01_01_10_00_00; the green B consumes target position 2, and the second extra B is gray.
- Start while busy, then reset mid-operation: issue start, pulse start again at cycle 3 and expect it to be ignored with one done only. Next, issue start and assert reset at cycle 4. Expect no done, result=0, win=0, ready=1 the cycle after reset; a following start scores normally.
- Input hold: change guess and target on the cycle after accept. The result must reflect the latched values.

Source files
------------

// File: rtl/wordle_pkg.sv
// Shared definitions for the Wordle scoring path: color codes, scorer
// states, word geometry and a byte-extraction helper.
package wordle_pkg;

   localparam int N_LETTERS = 5;
   localparam int CHAR_W    = 8;
   localparam int WORD_W    = N_LETTERS * CHAR_W;
   localparam int RESULT_W  = N_LETTERS * 2;

   typedef enum logic [1:0] {
      GRAY   = 2'b00,
      YELLOW = 2'b01,
      GREEN  = 2'b10
   } color_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GREEN,
      S_YELLOW,
      S_DONE
   } state_t;

   // Position 0 is the first letter and lives in the top byte of the word.
   function automatic logic [CHAR_W-1:0] letter_at(input logic [WORD_W-1:0] word,
                                                   input int pos);
      return word[(N_LETTERS-1-pos)*CHAR_W +: CHAR_W];
   endfunction

endpackage

// File: rtl/wordle_letter_find.sv
// Finds the lowest-index unconsumed target position holding a given letter.
module wordle_letter_find
   import wordle_pkg::*;
(
   input  logic [CHAR_W-1:0]    letter,
   input  logic [WORD_W-1:0]    target,
   input  logic [N_LETTERS-1:0] consumed,
   output logic                 found,
   output logic [N_LETTERS-1:0] hit
);

   // Priority search from the first letter onward; the first match wins.
   always_comb begin
      found = 1'b0;
      hit   = '0;
      for (int j = 0; j < N_LETTERS; j++) begin
         if (!found && !consumed[j] && (letter_at(target, j) == letter)) begin
            found  = 1'b1;
            hit[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wordle_scorer.sv
// Scores a latched guess against a latched target with standard Wordle
// duplicate handling: greens first in one cycle, then one yellow
// position per cycle, left to right.
module wordle_scorer
   import wordle_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [WORD_W-1:0]   guess,
   input  logic [WORD_W-1:0]   target,
   output logic                ready,
   output logic                done,
   output logic [RESULT_W-1:0] result,
   output logic                win
);

   localparam logic [RESULT_W-1:0] ALL_GREEN = 10'b10_10_10_10_10;

   state_t                state;
   state_t                state_next;
   logic [WORD_W-1:0]     guess_q;
   logic [WORD_W-1:0]     target_q;
   logic [N_LETTERS-1:0]  consumed;
   logic [RESULT_W-1:0]   work;
   logic [RESULT_W-1:0]   work_next;
   logic [2:0]            idx;
   logic [RESULT_W-1:0]   result_q;
   logic                  win_q;
   logic [CHAR_W-1:0]     cur_letter;
   logic                  find_found;
   logic [N_LETTERS-1:0]  find_hit;
   logic                  yellow_hit;

   assign cur_letter = letter_at(guess_q, int'(idx));

   wordle_letter_find u_find (
      .letter   (cur_letter),
      .target   (target_q),
      .consumed (consumed),
      .found    (find_found),
      .hit      (find_hit)
   );

   // State register; reset from any state abandons the current job.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Next-state sequencing: one green cycle, five yellow cycles, one done cycle.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (start) state_next = S_GREEN;
         S_GREEN:  state_next = S_YELLOW;
         S_YELLOW: if (idx == 3'd4) state_next = S_DONE;
         S_DONE:   state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Yellow decision for the current position, folded into the working result.
   always_comb begin
      yellow_hit = (color_t'(work[(N_LETTERS-1-int'(idx))*2 +: 2]) != GREEN) && find_found;
      work_next  = work;
      if (yellow_hit) work_next[(N_LETTERS-1-int'(idx))*2 +: 2] = YELLOW;
   end

   // Datapath: latch on accept, mark greens, walk yellows, publish on the last step.
   always_ff @(posedge clk) begin
      if (reset) begin
         guess_q  <= '0;
         target_q <= '0;
         consumed <= '0;
         work     <= '0;
         idx      <= '0;
         result_q <= '0;
         win_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  guess_q  <= guess;
                  target_q <= target;
                  consumed <= '0;
                  work     <= '0;
                  idx      <= '0;
                  result_q <= '0;
                  win_q    <= 1'b0;
               end
            end
            S_GREEN: begin
               for (int i = 0; i < N_LETTERS; i++) begin
                  if (letter_at(guess_q, i) == letter_at(target_q, i)) begin
                     work[(N_LETTERS-1-i)*2 +: 2] <= GREEN;
                     consumed[i]                  <= 1'b1;
                  end
               end
               idx <= '0;
            end
            S_YELLOW: begin
               work <= work_next;
               if (yellow_hit) consumed <= consumed | find_hit;
               idx <= idx + 3'd1;
               if (idx == 3'd4) begin
                  result_q <= work_next;
                  win_q    <= (work_next == ALL_GREEN);
               end
            end
            default: ;
         endcase
      end
   end

   assign ready  = (state == S_IDLE);
   assign done   = (state == S_DONE);
   assign result = result_q;
   assign win    = win_q;

endmodule

// File: tb/tb_wordle_scorer.sv
// Self-checking bench for wordle_scorer: directed Wordle cases plus
// randomized words scored by a letter-count reference model.
module tb_wordle_scorer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [39:0] guess;
   logic [39:0] target;
   logic        ready;
   logic        done;
   logic [9:0]  result;
   logic        win;

   int checks;
   int errors;

   wordle_scorer dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .guess  (guess),
      .target (target),
      .ready  (ready),
      .done   (done),
      .result (result),
      .win    (win)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Reference: greens first, then leftover target letters counted and
   // handed out left to right as yellows.
   function automatic logic [9:0] refScore(input logic [39:0] g, input logic [39:0] t);
      int          cnt [256];
      logic [9:0]  r;
      logic [7:0]  gb;
      logic [7:0]  tb;
      r = '0;
      foreach (cnt[k]) cnt[k] = 0;
      for (int i = 0; i < 5; i++) begin
         gb = g[(4-i)*8 +: 8];
         tb = t[(4-i)*8 +: 8];
         if (gb == tb) r[(4-i)*2 +: 2] = 2'b10;
         else          cnt[tb] = cnt[tb] + 1;
      end
      for (int i = 0; i < 5; i++) begin
         gb = g[(4-i)*8 +: 8];
         if (r[(4-i)*2 +: 2] != 2'b10 && cnt[gb] > 0) begin
            r[(4-i)*2 +: 2] = 2'b01;
            cnt[gb] = cnt[gb] - 1;
         end
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one full job and checks busy flags, latency, result, win and hold.
   task automatic applyStimulus(input logic [39:0] g, input logic [39:0] t,
                                input bit scramble, input logic [9:0] expRes,
                                input string tag);
      int lat;
      guess  = g;
      target = t;
      start  = 1'b1;
      tick();
      start  = 1'b0;
      if (scramble) begin
         guess  = {8'($urandom), $urandom};
         target = {8'($urandom), $urandom};
      end
      checkOutput({tag, "_ready_busy"}, 32'(ready), 32'd0);
      checkOutput({tag, "_result_cleared"}, 32'(result), 32'd0);
      lat = 1;
      while (done !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      checkOutput({tag, "_latency"}, 32'(lat), 32'd7);
      checkOutput({tag, "_result"}, 32'(result), 32'(expRes));
      checkOutput({tag, "_win"}, 32'(win), 32'(expRes == 10'b10_10_10_10_10));
      tick();
      checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
      checkOutput({tag, "_ready_after"}, 32'(ready), 32'd1);
      checkOutput({tag, "_result_hold"}, 32'(result), 32'(expRes));
   endtask

   initial begin
      logic [39:0] g;
      logic [39:0] t;
      logic [9:0]  expRes;
      logic [9:0]  seen;
      int          doneCount;

      checks = 0;
      errors = 0;
      reset  = 1'b1;
      start  = 1'b0;
      guess  = '0;
      target = '0;
      tick();
      tick();
      checkOutput("reset_ready", 32'(ready), 32'd1);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_result", 32'(result), 32'd0);
      checkOutput("reset_win", 32'(win), 32'd0);
      reset = 1'b0;
      tick();

      applyStimulus("ROBOT", "ROBOT", 1'b0, 10'b10_10_10_10_10, "exact");
      applyStimulus("PALES", "LAPSE", 1'b0, 10'b01_10_01_01_01, "anagram");
      applyStimulus("AAAAA", "CACAO", 1'b0, 10'b00_10_00_10_00, "excess_dup");
      applyStimulus("BOBBY", "ABBOT", 1'b0, 10'b01_01_10_00_00, "dup_yellow");
      applyStimulus("BOBBY", "ABBOT", 1'b1, 10'b01_01_10_00_00, "input_hold");

      // Start while busy must be ignored.
      guess  = "CRANE";
      target = "REACT";
      expRes = refScore("CRANE", "REACT");
      start  = 1'b1;
      tick();
      start  = 1'b0;
      tick();
      guess  = "ZZZZZ";
      start  = 1'b1;
      tick();
      start  = 1'b0;
      doneCount = 0;
      seen = '0;
      for (int k = 0; k < 15; k++) begin
         if (done === 1'b1) begin
            doneCount++;
            seen = result;
         end
         tick();
      end
      checkOutput("busy_done_count", 32'(doneCount), 32'd1);
      checkOutput("busy_result", 32'(seen), 32'(expRes));

      // Reset in the middle of scoring abandons the job.
      guess  = "ROBOT";
      target = "ROBOT";
      start  = 1'b1;
      tick();
      start  = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("midreset_ready", 32'(ready), 32'd1);
      checkOutput("midreset_done", 32'(done), 32'd0);
      checkOutput("midreset_result", 32'(result), 32'd0);
      checkOutput("midreset_win", 32'(win), 32'd0);
      doneCount = 0;
      for (int k = 0; k < 10; k++) begin
         if (done === 1'b1) doneCount++;
         tick();
      end
      checkOutput("midreset_no_done", 32'(doneCount), 32'd0);
      applyStimulus("LEVEL", "HELLO", 1'b0, refScore("LEVEL", "HELLO"), "after_reset");

      // Randomized words over a tiny alphabet to force duplicates.
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < 5; i++) begin
            g[i*8 +: 8] = 8'(65 + $urandom_range(0, 3));
            t[i*8 +: 8] = 8'(65 + $urandom_range(0, 3));
         end
         if (n % 7 == 3) g[8 +: 8] = 8'h00;
         if (n % 7 == 3) t[8 +: 8] = 8'h00;
         if (n % 5 == 0) t = g;
         applyStimulus(g, t, n[0], refScore(g, t), "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
